// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader driving the core load port
//
// Purpose: holds the core in register reset, clears its memory, packs incoming
// bytes little-endian into 32-bit words written to consecutive addresses, then
// releases the core and stops it on ebreak or after TIMEOUT run cycles.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, len_words    session request and word count (latched on accept)
//   in_valid/in_data    byte source, in_ready = loader accepts a byte
//   rom_wen/addr/wdata  core load-port write (one cycle per word)
//   cpu_reg_reset       core register reset (low only while running)
//   cpu_mem_reset       core memory clear (one cycle per session)
//   cpu_ebreak          core halt request, honoured only while running
//   busy, done, err     session status
//   run_cycles          cycles spent running in the last session

module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned MAX_WORDS = 4096,
    parameter logic [31:0] TIMEOUT   = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] len_words,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        rom_wen,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_wdata,
    output logic        cpu_reg_reset,
    output logic        cpu_mem_reset,
    input  logic        cpu_ebreak,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RECV,
        S_WRITE,
        S_RUN,
        S_HALT
    } state_t;

    state_t      state_q;
    logic [15:0] len_q;
    logic [15:0] index_q;
    logic [1:0]  byte_cnt_q;
    // Only the low three bytes need storing; the fourth goes straight to rom_wdata.
    logic [23:0] word_q;
    logic        rom_wen_q;
    logic [31:0] rom_addr_q;
    logic [31:0] rom_wdata_q;
    logic        reg_rst_q;
    logic        mem_rst_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] run_q;

    logic        len_bad;
    logic [31:0] write_addr;

    assign len_bad    = (len_words == 16'd0) || ({16'd0, len_words} > MAX_WORDS);
    assign write_addr = BASE_ADDR + {14'd0, index_q, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= 16'd0;
            index_q     <= 16'd0;
            byte_cnt_q  <= 2'd0;
            word_q      <= 24'd0;
            rom_wen_q   <= 1'b0;
            rom_addr_q  <= 32'd0;
            rom_wdata_q <= 32'd0;
            reg_rst_q   <= 1'b1;
            mem_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            run_q       <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        if (len_bad) begin
                            // Rejected request: report and park in IDLE, memory untouched.
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q    <= S_CLEAR;
                            len_q      <= len_words;
                            index_q    <= 16'd0;
                            byte_cnt_q <= 2'd0;
                            err_q      <= 1'b0;
                            done_q     <= 1'b0;
                            run_q      <= 32'd0;
                            mem_rst_q  <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end

                S_CLEAR: begin
                    state_q   <= S_RECV;
                    mem_rst_q <= 1'b0;
                end

                S_RECV: begin
                    if (in_valid) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= in_data;
                            2'd1: word_q[15:8]  <= in_data;
                            2'd2: word_q[23:16] <= in_data;
                            default: begin
                                state_q     <= S_WRITE;
                                rom_wen_q   <= 1'b1;
                                rom_addr_q  <= write_addr;
                                rom_wdata_q <= {in_data, word_q};
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    rom_wen_q   <= 1'b0;
                    rom_addr_q  <= 32'd0;
                    rom_wdata_q <= 32'd0;
                    if (index_q == len_q - 16'd1) begin
                        state_q   <= S_RUN;
                        reg_rst_q <= 1'b0;
                    end else begin
                        state_q <= S_RECV;
                        index_q <= index_q + 16'd1;
                    end
                end

                S_RUN: begin
                    // The cycle that sees ebreak or the timeout still counts as a run cycle.
                    run_q <= run_q + 32'd1;
                    if (cpu_ebreak) begin
                        state_q   <= S_HALT;
                        reg_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                    end else if (run_q == TIMEOUT - 32'd1) begin
                        state_q   <= S_HALT;
                        reg_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready is decoded straight from the state so it is valid in the same
    // cycle the source presents a byte.
    assign in_ready      = (state_q == S_RECV);
    assign rom_wen       = rom_wen_q;
    assign rom_addr      = rom_addr_q;
    assign rom_wdata     = rom_wdata_q;
    assign cpu_reg_reset = reg_rst_q;
    assign cpu_mem_reset = mem_rst_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign run_cycles    = run_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader

module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len_words = 16'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        rom_wen;
    logic [31:0] rom_addr;
    logic [31:0] rom_wdata;
    logic        cpu_reg_reset;
    logic        cpu_mem_reset;
    logic        cpu_ebreak = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] run_cycles;

    int tests = 0;
    int fails = 0;

    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          mem_rst_cnt = 0;
    int          bad_ready = 0;

    prog_loader #(
        .BASE_ADDR(32'h8000_0000),
        .MAX_WORDS(4096),
        .TIMEOUT  (32'd10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len_words    (len_words),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .rom_wen      (rom_wen),
        .rom_addr     (rom_addr),
        .rom_wdata    (rom_wdata),
        .cpu_reg_reset(cpu_reg_reset),
        .cpu_mem_reset(cpu_mem_reset),
        .cpu_ebreak   (cpu_ebreak),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .run_cycles   (run_cycles)
    );

    always #5 clk = ~clk;

    // Write capture and in_ready sanity, sampled mid-cycle.
    always @(negedge clk) begin
        if (rom_wen) begin
            cap_addr.push_back(rom_addr);
            cap_data.push_back(rom_wdata);
        end
        if (cpu_mem_reset) mem_rst_cnt++;
        if (in_ready && (rom_wen || cpu_mem_reset || !busy || !cpu_reg_reset)) bad_ready++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len);
        start = 1'b1;
        len_words = len;
        tick();
        start = 1'b0;
    endtask

    // Present a byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_data = b;
        n = 0;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_byte timeout: byte %02h not accepted in %0d cycles", b, n);
        end
    endtask

    task automatic clear_caps;
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) tick();
        tests++; if (cpu_reg_reset !== 1'b1) begin fails++; $display("FAIL reset_reg_reset got %b want 1", cpu_reg_reset); end
        tests++; if ({rom_wen, rom_addr, rom_wdata} !== 65'd0) begin fails++; $display("FAIL reset_rom got %b %h %h want 0", rom_wen, rom_addr, rom_wdata); end
        tests++; if ({cpu_mem_reset, in_ready, busy, done, err} !== 5'd0) begin fails++; $display("FAIL reset_flags got %b want 00000", {cpu_mem_reset, in_ready, busy, done, err}); end
        tests++; if (run_cycles !== 32'd0) begin fails++; $display("FAIL reset_run_cycles got %0d want 0", run_cycles); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_two_word;
        logic [7:0] b [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
        clear_caps();
        do_start(16'd2);
        tests++; if ({cpu_mem_reset, cpu_reg_reset, busy, in_ready} !== 4'b1110) begin fails++; $display("FAIL two_clear got mem/reg/busy/rdy %b want 1110", {cpu_mem_reset, cpu_reg_reset, busy, in_ready}); end
        for (int i = 0; i < 8; i++) begin
            send_byte(b[i]);
            if (i == 3) begin
                tests++; if ({rom_wen, rom_addr, rom_wdata} !== {1'b1, 32'h8000_0000, 32'h0010_0513}) begin fails++; $display("FAIL two_w0_latency got %b %h %h want 1 80000000 00100513", rom_wen, rom_addr, rom_wdata); end
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL two_write_ready got %b want 0", in_ready); end
            end
        end
        in_valid = 1'b0;
        tick();
        tests++; if ({cpu_reg_reset, rom_wen, rom_addr, busy} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin fails++; $display("FAIL two_run_entry got reg %b wen %b addr %h busy %b want 0 0 0 1", cpu_reg_reset, rom_wen, rom_addr, busy); end
        tick();
        tick();
        cpu_ebreak = 1'b1;
        tick();
        cpu_ebreak = 1'b0;
        tests++; if ({done, cpu_reg_reset, err, busy} !== 4'b1100) begin fails++; $display("FAIL two_halt got done/reg/err/busy %b want 1100", {done, cpu_reg_reset, err, busy}); end
        tests++; if (run_cycles !== 32'd3) begin fails++; $display("FAIL two_run_cycles got %0d want 3", run_cycles); end
        tests++; if (cap_addr.size() != 2) begin fails++; $display("FAIL two_write_count got %0d want 2", cap_addr.size()); end
        else if (cap_addr[0] !== 32'h8000_0000 || cap_data[0] !== 32'h0010_0513 ||
                 cap_addr[1] !== 32'h8000_0004 || cap_data[1] !== 32'h0010_0073) begin
            fails++;
            $display("FAIL two_words got %h:%h %h:%h want 80000000:00100513 80000004:00100073", cap_addr[0], cap_data[0], cap_addr[1], cap_data[1]);
        end
    endtask

    task automatic test_stall;
        int gaps [12] = '{0, 2, 1, 0, 3, 0, 1, 2, 0, 0, 4, 1};
        logic [31:0] exp_d [3] = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09};
        logic [7:0]  bv;
        int bad0;
        clear_caps();
        bad0 = bad_ready;
        do_start(16'd3);
        tests++; if ({run_cycles, done} !== 33'd0) begin fails++; $display("FAIL stall_restart_clear got run %0d done %b want 0 0", run_cycles, done); end
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b0;
            repeat (gaps[i]) tick();
            bv = 8'(i + 1);
            send_byte(bv);
        end
        in_valid = 1'b0;
        tick();
        cpu_ebreak = 1'b1;
        tick();
        cpu_ebreak = 1'b0;
        tests++; if ({done, err, run_cycles} !== {1'b1, 1'b0, 32'd1}) begin fails++; $display("FAIL stall_halt got done %b err %b run %0d want 1 0 1", done, err, run_cycles); end
        tests++; if (cap_addr.size() != 3) begin fails++; $display("FAIL stall_write_count got %0d want 3", cap_addr.size()); end
        else begin
            for (int w = 0; w < 3; w++) begin
                tests++;
                if (cap_addr[w] !== 32'h8000_0000 + 32'(4 * w) || cap_data[w] !== exp_d[w]) begin
                    fails++;
                    $display("FAIL stall_word%0d got %h:%h want %h:%h", w, cap_addr[w], cap_data[w], 32'h8000_0000 + 32'(4 * w), exp_d[w]);
                end
            end
        end
        tests++; if (bad_ready != bad0) begin fails++; $display("FAIL stall_ready_outside_recv got %0d want 0", bad_ready - bad0); end
    endtask

    task automatic test_illegal;
        int mr0;
        clear_caps();
        mr0 = mem_rst_cnt;
        do_start(16'd0);
        tests++; if ({err, done, busy, cpu_mem_reset} !== 4'b1000) begin fails++; $display("FAIL illegal_len0 got err/done/busy/mrst %b want 1000", {err, done, busy, cpu_mem_reset}); end
        do_start(16'd4097);
        repeat (3) tick();
        tests++; if ({err, done, busy, in_ready} !== 4'b1000) begin fails++; $display("FAIL illegal_len4097 got err/done/busy/rdy %b want 1000", {err, done, busy, in_ready}); end
        tests++; if (cap_addr.size() != 0 || mem_rst_cnt != mr0) begin fails++; $display("FAIL illegal_side_effects got wen %0d mrst %0d want 0 0", cap_addr.size(), mem_rst_cnt - mr0); end
        do_start(16'd4096);
        tests++; if ({err, busy, cpu_mem_reset} !== 3'b011) begin fails++; $display("FAIL max_len_accept got err/busy/mrst %b want 011", {err, busy, cpu_mem_reset}); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid;
        clear_caps();
        do_start(16'd2);
        send_byte(8'hEE);
        send_byte(8'hFF);
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_recv got in_ready %b want 1", in_ready); end
        #2 reset = 1'b1;
        #1;
        tests++; if ({cpu_reg_reset, cpu_mem_reset, in_ready, busy, done, err, rom_wen} !== 7'b1000000 || run_cycles !== 32'd0) begin
            fails++; $display("FAIL mid_async_reset got %b run %0d want 1000000 0", {cpu_reg_reset, cpu_mem_reset, in_ready, busy, done, err, rom_wen}, run_cycles);
        end
        tick();
        reset = 1'b0;
        tick();
        do_start(16'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        in_valid = 1'b0;
        tests++; if ({rom_wen, rom_addr, rom_wdata} !== {1'b1, 32'h8000_0000, 32'hDDCC_BBAA}) begin fails++; $display("FAIL mid_reload got %b %h %h want 1 80000000 ddccbbaa", rom_wen, rom_addr, rom_wdata); end
        tick();
        cpu_ebreak = 1'b1;
        tick();
        cpu_ebreak = 1'b0;
        tests++; if (cap_addr.size() != 1) begin fails++; $display("FAIL mid_write_count got %0d want 1", cap_addr.size()); end
    endtask

    task automatic test_timeout;
        int run_seen;
        int n;
        do_start(16'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        in_valid = 1'b0;
        run_seen = 0;
        n = 0;
        cpu_ebreak = 1'b0;
        while (!done && n < 50) begin
            tick();
            if (cpu_reg_reset === 1'b0) run_seen++;
            n++;
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL timeout_halt got done %b after %0d cycles want 1", done, n); end
        tests++; if ({err, cpu_reg_reset} !== 2'b11 || run_cycles !== 32'd10) begin fails++; $display("FAIL timeout_status got err %b reg %b run %0d want 1 1 10", err, cpu_reg_reset, run_cycles); end
        tests++; if (run_seen != 10) begin fails++; $display("FAIL timeout_run_len got %0d want 10", run_seen); end
    endtask

    task automatic test_restart;
        int mr0;
        clear_caps();
        mr0 = mem_rst_cnt;
        do_start(16'd1);
        tests++; if ({cpu_mem_reset, done, err} !== 3'b100 || run_cycles !== 32'd0) begin fails++; $display("FAIL restart_clear got mrst/done/err %b run %0d want 100 0", {cpu_mem_reset, done, err}, run_cycles); end
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        in_valid = 1'b0;
        tick();
        repeat (9) tick();
        cpu_ebreak = 1'b1;
        tick();
        cpu_ebreak = 1'b0;
        tests++; if ({done, err} !== 2'b10 || run_cycles !== 32'd10) begin fails++; $display("FAIL restart_ebreak_at_timeout got done %b err %b run %0d want 1 0 10", done, err, run_cycles); end
        tests++; if (cap_addr.size() != 1 || cap_addr[0] !== 32'h8000_0000 || cap_data[0] !== 32'h4433_2211) begin
            fails++; $display("FAIL restart_word got n %0d %h:%h want 1 80000000:44332211", cap_addr.size(), cap_addr.size() > 0 ? cap_addr[0] : 32'd0, cap_data.size() > 0 ? cap_data[0] : 32'd0);
        end
        tests++; if (mem_rst_cnt - mr0 != 1) begin fails++; $display("FAIL restart_mem_reset_pulse got %0d want 1", mem_rst_cnt - mr0); end
    endtask

    initial begin
        #1;
        test_reset();
        test_two_word();
        test_stall();
        test_illegal();
        test_reset_mid();
        test_timeout();
        test_restart();
        tests++; if (bad_ready != 0) begin fails++; $display("FAIL ready_outside_recv got %0d want 0", bad_ready); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
